// File: rtl/gf16_sqscmul_pipe.sv
// ---------------------------------------------------------------------------
// gf16_sqscmul_pipe
//
// Multi-lane, first-order two-share masked GF(2^4) square-scale-multiply
// unit (the Canright inverter term). Per 4-bit lane it produces output
// shares y0/y1 with
//   y0 ^ y1 = NU*(a^b)^2 ^ a*b,   a = a0^a1,  b = b0^b1
// Field: polynomial basis, modulus x^4 + x + 1.
//
// Pipeline: four domain terms (s00, s01, s10, s11) are registered
// separately in stage 1, then compressed pairwise into y0/y1, followed by
// PIPE optional register stages. The whole pipeline stalls as one unit
// when the output beat is not accepted; there is no skid buffer.
//
// Parameters:
//   LANES  number of independent 4-bit lanes
//   PIPE   extra register stages after compression (0..3)
//   NU     GF(2^4) scaling constant
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset, priority over stall/advance
//   in_valid   input beat valid
//   in_ready   unit can accept a beat (depends on out_valid/out_ready only)
//   a0, a1     shares of operand a, lane k in bits [4k+3:4k]
//   b0, b1     shares of operand b
//   r          fresh mask, one nibble per lane, sampled on accepted beats
//   out_valid  output beat valid, held until accepted
//   out_ready  downstream accepts the output beat
//   y0, y1     output shares
// ---------------------------------------------------------------------------
module gf16_sqscmul_pipe #(
  parameter int         LANES = 1,
  parameter int         PIPE  = 0,
  parameter logic [3:0] NU    = 4'h9
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*LANES-1:0] a0,
  input  logic [4*LANES-1:0] a1,
  input  logic [4*LANES-1:0] b0,
  input  logic [4*LANES-1:0] b1,
  input  logic [4*LANES-1:0] r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*LANES-1:0] y0,
  output logic [4*LANES-1:0] y1
);

  localparam int W = 4 * LANES;

  // Full GF(2^4) multiply: shift-and-add, reducing by x^4 = x + 1 each
  // time the running multiple of x is doubled.
  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // NU * v^2; GF(2)-linear, so it may be applied to each share domain.
  function automatic logic [3:0] gf_sqsc(input logic [3:0] v);
    return gf_mul(NU, gf_mul(v, v));
  endfunction

  // -------------------------------------------------------------------------
  // Handshake: a stalled output freezes every stage.
  // -------------------------------------------------------------------------
  logic w_stall;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // -------------------------------------------------------------------------
  // Domain terms. Each term only mixes shares that may legally meet; the
  // cross-domain products are blinded by r before they are ever combined.
  // -------------------------------------------------------------------------
  logic [W-1:0] w_s00;
  logic [W-1:0] w_s01;
  logic [W-1:0] w_s10;
  logic [W-1:0] w_s11;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [3:0] w_a0;
    logic [3:0] w_a1;
    logic [3:0] w_b0;
    logic [3:0] w_b1;
    logic [3:0] w_r;

    assign w_a0 = a0[4*k +: 4];
    assign w_a1 = a1[4*k +: 4];
    assign w_b0 = b0[4*k +: 4];
    assign w_b1 = b1[4*k +: 4];
    assign w_r  = r[4*k +: 4];

    assign w_s00[4*k +: 4] = gf_sqsc(w_a0 ^ w_b0) ^ gf_mul(w_a0, w_b0);
    assign w_s01[4*k +: 4] = gf_mul(w_a0, w_b1) ^ w_r;
    assign w_s10[4*k +: 4] = gf_mul(w_a1, w_b0) ^ w_r;
    assign w_s11[4*k +: 4] = gf_sqsc(w_a1 ^ w_b1) ^ gf_mul(w_a1, w_b1);
  end

  // -------------------------------------------------------------------------
  // Stage 1: glitch barrier. The four terms sit in separate registers so no
  // combinational path XORs cross-domain values before they settle.
  // -------------------------------------------------------------------------
  logic         r_v1;
  logic [W-1:0] r_s00;
  logic [W-1:0] r_s01;
  logic [W-1:0] r_s10;
  logic [W-1:0] r_s11;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the stage order cannot race.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: share registers are cleared too, not just valid bits, so no
      // residue of a flushed beat survives reset.
      r_v1  <= 1'b0;
      r_s00 <= '0;
      r_s01 <= '0;
      r_s10 <= '0;
      r_s11 <= '0;
    end else if (!w_stall) begin
      // Data loads even on a bubble, so the stage only ever holds the
      // current beat's terms.
      r_v1  <= in_valid;
      r_s00 <= w_s00;
      r_s01 <= w_s01;
      r_s10 <= w_s10;
      r_s11 <= w_s11;
    end
  end

  // Compression: each output share combines only its own domain pair.
  logic [W-1:0] w_y0;
  logic [W-1:0] w_y1;

  assign w_y0 = r_s00 ^ r_s01;
  assign w_y1 = r_s10 ^ r_s11;

  // -------------------------------------------------------------------------
  // Optional output pipeline. Shares remain in separate registers.
  // -------------------------------------------------------------------------
  if (PIPE == 0) begin : g_nopipe
    assign out_valid = r_v1;
    assign y0        = w_y0;
    assign y1        = w_y1;
  end else begin : g_pipe
    logic [W-1:0]    r_y0 [PIPE];
    logic [W-1:0]    r_y1 [PIPE];
    logic [PIPE-1:0] r_v;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_v <= '0;
        for (int i = 0; i < PIPE; i++) begin
          r_y0[i] <= '0;
          r_y1[i] <= '0;
        end
      end else if (!w_stall) begin
        r_v[0]  <= r_v1;
        r_y0[0] <= w_y0;
        r_y1[0] <= w_y1;
        for (int i = 1; i < PIPE; i++) begin
          r_v[i]  <= r_v[i-1];
          r_y0[i] <= r_y0[i-1];
          r_y1[i] <= r_y1[i-1];
        end
      end
    end

    assign out_valid = r_v[PIPE-1];
    assign y0        = r_y0[PIPE-1];
    assign y1        = r_y1[PIPE-1];
  end

endmodule

// File: tb/tb_gf16_sqscmul_pipe.sv
// ---------------------------------------------------------------------------
// Bench for gf16_sqscmul_pipe. Two instances share clock and reset:
//   d0: LANES=1, PIPE=0   d2: LANES=4, PIPE=2
// Expected shares come from an independent GF(2^4) model (polynomial
// product then reduction) and are queued when a beat is accepted, then
// popped when the DUT hands a beat out.
// ---------------------------------------------------------------------------
module tb_gf16_sqscmul_pipe;

  typedef struct {
    logic [15:0] y0;
    logic [15:0] y1;
    logic [15:0] y;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // d0 signals
  logic       d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready;
  logic [3:0] d0_a0, d0_a1, d0_b0, d0_b1, d0_r, d0_y0, d0_y1;
  // d2 signals
  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [15:0] d2_a0, d2_a1, d2_b0, d2_b1, d2_r, d2_y0, d2_y1;

  gf16_sqscmul_pipe #(.LANES(1), .PIPE(0), .NU(4'h9)) u_d0 (
    .CLK(CLK), .RST(RST),
    .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .a0(d0_a0), .a1(d0_a1), .b0(d0_b0), .b1(d0_b1), .r(d0_r),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready),
    .y0(d0_y0), .y1(d0_y1)
  );

  gf16_sqscmul_pipe #(.LANES(4), .PIPE(2), .NU(4'h9)) u_d2 (
    .CLK(CLK), .RST(RST),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .a0(d2_a0), .a1(d2_a1), .b0(d2_b0), .b1(d2_b1), .r(d2_r),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .y0(d2_y0), .y1(d2_y1)
  );

  exp_t q0[$];
  exp_t q2[$];
  int   n_vec = 0;
  int   n_err = 0;

  // d2 stall / latency tracking
  logic        prev_stall = 1'b0;
  logic [15:0] hold_y0, hold_y1;
  int          first_acc, first_out, last_out, n_out;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] m_sqsc(input logic [3:0] v);
    return m_mul(4'h9, m_mul(v, v));
  endfunction

  function automatic exp_t m_beat(input logic [15:0] a0, input logic [15:0] a1,
                                  input logic [15:0] b0, input logic [15:0] b1,
                                  input logic [15:0] r, input int lanes);
    exp_t e;
    logic [3:0] x0, x1, z0, z1, rk;
    e.y0 = '0;
    e.y1 = '0;
    e.y  = '0;
    for (int k = 0; k < lanes; k++) begin
      x0 = a0[4*k +: 4]; x1 = a1[4*k +: 4];
      z0 = b0[4*k +: 4]; z1 = b1[4*k +: 4];
      rk = r[4*k +: 4];
      e.y0[4*k +: 4] = m_sqsc(x0 ^ z0) ^ m_mul(x0, z0) ^ m_mul(x0, z1) ^ rk;
      e.y1[4*k +: 4] = m_mul(x1, z0) ^ rk ^ m_sqsc(x1 ^ z1) ^ m_mul(x1, z1);
    end
    return e;
  endfunction

  function automatic logic [15:0] m_y16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] y;
    for (int k = 0; k < 4; k++)
      y[4*k +: 4] = m_sqsc(a[4*k +: 4] ^ b[4*k +: 4]) ^ m_mul(a[4*k +: 4], b[4*k +: 4]);
    return y;
  endfunction

  // ---------------- per-cycle drivers (start/end at negedge) ----------------
  task automatic step0(input logic v, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] r,
                       input logic [3:0] ey, input logic ordy);
    exp_t e;
    d0_in_valid = v; d0_a0 = a0; d0_a1 = a1; d0_b0 = b0; d0_b1 = b1; d0_r = r;
    d0_out_ready = ordy;
    #1;
    if (d0_out_valid && d0_out_ready) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL d0_unexpected_out: got y0=%h y1=%h, required no beat", d0_y0, d0_y1);
      end else begin
        e = q0.pop_front();
        n_vec += 2;
        if ({d0_y0, d0_y1} !== {e.y0[3:0], e.y1[3:0]}) begin
          n_err++;
          $display("FAIL d0_shares: got y0=%h y1=%h, required y0=%h y1=%h",
                   d0_y0, d0_y1, e.y0[3:0], e.y1[3:0]);
        end
        if ((d0_y0 ^ d0_y1) !== e.y[3:0]) begin
          n_err++;
          $display("FAIL d0_xor: got %h, required %h", d0_y0 ^ d0_y1, e.y[3:0]);
        end
      end
    end
    if (v && d0_in_ready && !RST) begin
      e   = m_beat({12'b0, a0}, {12'b0, a1}, {12'b0, b0}, {12'b0, b1}, {12'b0, r}, 1);
      e.y = {12'b0, ey};
      q0.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic step2(input logic v, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] r,
                       input logic [15:0] ey, input logic ordy, output logic acc);
    exp_t e;
    d2_in_valid = v; d2_a0 = a0; d2_a1 = a1; d2_b0 = b0; d2_b1 = b1; d2_r = r;
    d2_out_ready = ordy;
    #1;
    if (prev_stall) begin
      n_vec++;
      if ({d2_out_valid, d2_y0, d2_y1} !== {1'b1, hold_y0, hold_y1}) begin
        n_err++;
        $display("FAIL d2_hold: got v=%b y0=%h y1=%h, required v=1 y0=%h y1=%h",
                 d2_out_valid, d2_y0, d2_y1, hold_y0, hold_y1);
      end
    end
    if (d2_out_valid && !d2_out_ready) begin
      n_vec++;
      if (d2_in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL d2_in_ready_stall: got %b, required 0", d2_in_ready);
      end
      hold_y0 = d2_y0; hold_y1 = d2_y1; prev_stall = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end
    if (d2_out_valid && d2_out_ready) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_out++;
      if (q2.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL d2_unexpected_out: got y0=%h y1=%h, required no beat", d2_y0, d2_y1);
      end else begin
        e = q2.pop_front();
        n_vec += 2;
        if ({d2_y0, d2_y1} !== {e.y0, e.y1}) begin
          n_err++;
          $display("FAIL d2_shares: got y0=%h y1=%h, required y0=%h y1=%h",
                   d2_y0, d2_y1, e.y0, e.y1);
        end
        if ((d2_y0 ^ d2_y1) !== e.y) begin
          n_err++;
          $display("FAIL d2_xor: got %h, required %h", d2_y0 ^ d2_y1, e.y);
        end
      end
    end
    acc = v && d2_in_ready && !RST;
    if (acc) begin
      if (first_acc < 0) first_acc = cyc;
      e   = m_beat(a0, a1, b0, b1, r, 4);
      e.y = ey;
      q2.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic drain0();
    for (int i = 0; i < 10 && q0.size() > 0; i++) step0(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    n_vec++;
    if (q0.size() != 0) begin
      n_err++;
      $display("FAIL d0_drain: %0d beats outstanding, required 0", q0.size());
    end
  endtask

  task automatic drain2();
    logic acc;
    for (int i = 0; i < 20 && q2.size() > 0; i++) step2(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, acc);
    n_vec++;
    if (q2.size() != 0) begin
      n_err++;
      $display("FAIL d2_drain: %0d beats outstanding, required 0", q2.size());
    end
  endtask

  task automatic rand_split(input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] a0, output logic [15:0] a1,
                            output logic [15:0] b0, output logic [15:0] b1,
                            output logic [15:0] r);
    a0 = 16'($urandom); a1 = a0 ^ a;
    b0 = 16'($urandom); b1 = b0 ^ b;
    r  = 16'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1;
    d0_in_valid = 1'b1; d0_out_ready = 1'b0;
    d0_a0 = 4'h3; d0_a1 = 4'h5; d0_b0 = 4'h7; d0_b1 = 4'h9; d0_r = 4'hB;
    d2_in_valid = 1'b1; d2_out_ready = 1'b0;
    d2_a0 = 16'h1234; d2_a1 = 16'h5678; d2_b0 = 16'h9ABC; d2_b1 = 16'hDEF0; d2_r = 16'h1357;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    d0_in_valid = 1'b0;
    d2_in_valid = 1'b0;
    #1;
    n_vec += 2;
    if ({d0_out_valid, d0_y0, d0_y1, d0_in_ready} !== {1'b0, 4'h0, 4'h0, 1'b1}) begin
      n_err++;
      $display("FAIL d0_reset: got v=%b y0=%h y1=%h rdy=%b, required v=0 y0=0 y1=0 rdy=1",
               d0_out_valid, d0_y0, d0_y1, d0_in_ready);
    end
    if ({d2_out_valid, d2_y0, d2_y1, d2_in_ready} !== {1'b0, 16'h0, 16'h0, 1'b1}) begin
      n_err++;
      $display("FAIL d2_reset: got v=%b y0=%h y1=%h rdy=%b, required v=0 y0=0 y1=0 rdy=1",
               d2_out_valid, d2_y0, d2_y1, d2_in_ready);
    end
    @(negedge CLK);
  endtask

  task automatic test_unmasked();
    step0(1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 1'b1);
    n_vec++;
    if (d0_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL d0_latency: got out_valid=%b one cycle after accept, required 1", d0_out_valid);
    end
    drain0();
  endtask

  task automatic test_masked();
    logic [15:0] a0, a1, b0, b1, r;
    step0(1'b1, 4'h7, 4'h5, 4'hC, 4'hF, 4'hA, 4'hF, 1'b1);
    for (int i = 0; i < 200; i++) begin
      rand_split(16'h2, 16'h3, a0, a1, b0, b1, r);
      step0(1'b1, a0[3:0], a1[3:0], b0[3:0], b1[3:0], r[3:0], 4'hF, 1'b1);
    end
    drain0();
  endtask

  task automatic test_lanes();
    logic [15:0] a0, a1, b0, b1, r;
    logic acc;
    // lane0 a=b=4 -> 3, lane1 a=b=1 -> 1, lanes 2,3 a=b=0 -> 0
    for (int i = 0; i < 4; i++) begin
      rand_split(16'h0014, 16'h0014, a0, a1, b0, b1, r);
      step2(1'b1, a0, a1, b0, b1, r, 16'h0013, 1'b1, acc);
    end
    drain2();
  endtask

  task automatic test_stream();
    logic [15:0] a, b, a0, a1, b0, b1, r;
    logic acc;
    first_acc = -1; first_out = -1; last_out = -1; n_out = 0;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      rand_split(a, b, a0, a1, b0, b1, r);
      step2(1'b1, a0, a1, b0, b1, r, m_y16(a, b), 1'b1, acc);
    end
    drain2();
    n_vec += 2;
    if (first_out - first_acc !== 3) begin
      n_err++;
      $display("FAIL d2_latency: got %0d cycles, required 3", first_out - first_acc);
    end
    if (n_out !== 10 || last_out - first_out !== 9) begin
      n_err++;
      $display("FAIL d2_throughput: got %0d beats over %0d cycles, required 10 over 9",
               n_out, last_out - first_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba[12], bb[12], ba0[12], ba1[12], bb0[12], bb1[12], br[12];
    logic acc;
    int idx;
    for (int i = 0; i < 12; i++) begin
      ba[i] = 16'($urandom); bb[i] = 16'($urandom);
      rand_split(ba[i], bb[i], ba0[i], ba1[i], bb0[i], bb1[i], br[i]);
    end
    idx = 0;
    for (int c = 0; c < 40 && (idx < 12 || q2.size() > 0); c++) begin
      if (idx < 12)
        step2(1'b1, ba0[idx], ba1[idx], bb0[idx], bb1[idx], br[idx],
              m_y16(ba[idx], bb[idx]), !(c >= 6 && c < 10), acc);
      else
        step2(1'b0, 0, 0, 0, 0, 0, 0, !(c >= 6 && c < 10), acc);
      if (acc) idx++;
    end
    n_vec++;
    if (idx !== 12 || q2.size() != 0) begin
      n_err++;
      $display("FAIL d2_backpressure: got %0d accepted %0d outstanding, required 12 and 0",
               idx, q2.size());
    end
  endtask

  task automatic test_reset_flush();
    logic [15:0] a0, a1, b0, b1, r;
    logic acc;
    for (int i = 0; i < 3; i++) begin
      rand_split(16'h00A5, 16'h005A, a0, a1, b0, b1, r);
      step2(1'b1, a0, a1, b0, b1, r, m_y16(16'h00A5, 16'h005A), 1'b1, acc);
    end
    RST = 1'b1;
    d2_in_valid = 1'b1;
    d2_out_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    d2_in_valid = 1'b0;
    #1;
    n_vec++;
    if ({d2_out_valid, d2_y0, d2_y1, d2_in_ready} !== {1'b0, 16'h0, 16'h0, 1'b1}) begin
      n_err++;
      $display("FAIL d2_flush: got v=%b y0=%h y1=%h rdy=%b, required v=0 y0=0 y1=0 rdy=1",
               d2_out_valid, d2_y0, d2_y1, d2_in_ready);
    end
    q2.delete();
    prev_stall = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      step2(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, acc);
      n_vec++;
      if (d2_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL d2_ghost: got out_valid=%b after flush, required 0", d2_out_valid);
      end
    end
    rand_split(16'h0123, 16'h4567, a0, a1, b0, b1, r);
    step2(1'b1, a0, a1, b0, b1, r, m_y16(16'h0123, 16'h4567), 1'b1, acc);
    drain2();
  endtask

  initial begin
    test_reset();
    test_unmasked();
    test_masked();
    test_lanes();
    test_stream();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
